// File: rtl/rtx_frame_writer.sv
// Receives the rtx pixel stream, converts (h,v) to a linear framebuffer address and issues
// writes through a first-word-fall-through FIFO; overflow and out-of-range pixels are counted.
module rtx_frame_writer #(
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned HEIGHT     = 720,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned ADDR_W    = $clog2(WIDTH * HEIGHT),
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       pixel_in,
  input  logic [10:0]       pixel_h,
  input  logic [9:0]        pixel_v,
  input  logic              pixel_valid,
  input  logic              frame_clear,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count,
  output logic [15:0]       oob_count,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = ADDR_W + 16;
  localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);

  // S0: captured pixel and bounds result
  logic              s0_valid_q, s0_valid_d;
  logic              s0_inb_q, s0_inb_d;
  logic [15:0]       s0_data_q, s0_data_d;
  logic [10:0]       s0_h_q, s0_h_d;
  logic [9:0]        s0_v_q, s0_v_d;

  // S1: computed address, ready to push
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [15:0]       s1_data_q, s1_data_d;

  logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic [15:0]       oob_count_q, oob_count_d;

  logic              fifo_empty;
  logic              pop;
  logic              push_req;
  logic              push;
  logic              drop;
  logic              oob_hit;
  logic [ENT_W-1:0]  head;

  assign fifo_empty = (level_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];

  // Clear takes priority over every handshake, push and count in its cycle.
  assign pop      = !fifo_empty && mem_ready && !frame_clear;
  assign push_req = s1_valid_q && !frame_clear;
  assign push     = push_req && ((level_q != LVL_FULL) || pop);
  assign drop     = push_req && !push;
  assign oob_hit  = s0_valid_q && !s0_inb_q && !frame_clear;

  always_comb begin
    s0_valid_d = pixel_valid && !frame_clear;
    s0_data_d  = s0_data_q;
    s0_h_d     = s0_h_q;
    s0_v_d     = s0_v_q;
    s0_inb_d   = s0_inb_q;
    if (pixel_valid) begin
      s0_data_d = pixel_in;
      s0_h_d    = pixel_h;
      s0_v_d    = pixel_v;
      s0_inb_d  = ({1'b0, pixel_h} < 12'(WIDTH)) && ({1'b0, pixel_v} < 11'(HEIGHT));
    end
  end

  always_comb begin
    s1_valid_d = s0_valid_q && s0_inb_q && !frame_clear;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    if (s0_valid_q && s0_inb_q) begin
      s1_addr_d = ADDR_W'(s0_v_q) * ADDR_W'(WIDTH) + ADDR_W'(s0_h_q);
      s1_data_d = s0_data_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (frame_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    wr_cnt_d      = wr_cnt_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    oob_count_d   = oob_count_q;
    if (frame_clear) begin
      wr_cnt_d = '0;
    end else if (pop) begin
      if (wr_cnt_q == FRAME_LAST) begin
        wr_cnt_d      = '0;
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      end
    end
    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + 16'd1;
    if (oob_hit && (oob_count_q != '1)) oob_count_d = oob_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q    <= 1'b0;
      s0_inb_q      <= 1'b0;
      s0_data_q     <= '0;
      s0_h_q        <= '0;
      s0_v_q        <= '0;
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      s1_data_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      wr_cnt_q      <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      oob_count_q   <= '0;
    end else begin
      s0_valid_q    <= s0_valid_d;
      s0_inb_q      <= s0_inb_d;
      s0_data_q     <= s0_data_d;
      s0_h_q        <= s0_h_d;
      s0_v_q        <= s0_v_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      s1_data_q     <= s1_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      wr_cnt_q      <= wr_cnt_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      oob_count_q   <= oob_count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {s1_addr_q, s1_data_q};
  end

  assign mem_valid   = !fifo_empty;
  assign mem_addr    = fifo_empty ? '0 : head[ENT_W-1:16];
  assign mem_data    = fifo_empty ? '0 : head[15:0];
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign oob_count   = oob_count_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_rtx_frame_writer.sv
// Bench for rtx_frame_writer (8x4 frame, 16-deep FIFO): directed vector table, multi-cycle
// sequences and randomized traffic, all checked against a queue-based reference model.
module tb_rtx_frame_writer;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pixel_in = '0;
  logic [10:0] pixel_h = '0;
  logic [9:0]  pixel_v = '0;
  logic        pixel_valid = 1'b0;
  logic        frame_clear = 1'b0;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic [15:0] oob_count;
  logic [4:0]  fifo_level;

  rtx_frame_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_h(pixel_h), .pixel_v(pixel_v),
    .pixel_valid(pixel_valid), .frame_clear(frame_clear), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .frame_done(frame_done), .frame_count(frame_count), .drop_count(drop_count),
    .oob_count(oob_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int s; bit inb; int addr; int data; } pend_t;
  typedef struct { int h; int v; int data; bit exp_valid; int exp_addr; } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: accepted writes queue, in-flight pixels tagged with sample edge.
  wr_t   mfifo[$];
  pend_t mpend[$];
  wr_t   wlog[$];
  int    ncyc = 0;
  int    mwr = 0, mframes = 0, mdrop = 0, moob = 0;
  bit    mfd = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mfifo.delete(); mpend.delete();
    mwr = 0; mframes = 0; mdrop = 0; moob = 0; mfd = 0;
  endtask

  task automatic model_edge();
    pend_t np[$];
    bit    fd;
    fd = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (frame_clear) begin
      mfifo.delete(); mpend.delete(); mwr = 0;
    end else begin
      if (mfifo.size() > 0 && mem_ready) begin
        void'(mfifo.pop_front());
        if (mwr == FRAME - 1) begin
          mwr = 0; mframes = (mframes + 1) % 65536; fd = 1;
        end else mwr++;
      end
      foreach (mpend[i]) begin
        if (mpend[i].s + 1 == ncyc && !mpend[i].inb) begin
          if (moob < 65535) moob++;
        end else if (mpend[i].s + 2 == ncyc) begin
          if (mfifo.size() < DEPTH) mfifo.push_back('{mpend[i].addr, mpend[i].data});
          else if (mdrop < 65535) mdrop++;
        end else np.push_back(mpend[i]);
      end
      mpend = np;
      if (pixel_valid) begin
        pend_t p;
        p.s = ncyc;
        p.inb = (int'(pixel_h) < W) && (int'(pixel_v) < H);
        p.addr = p.inb ? int'(pixel_v) * W + int'(pixel_h) : 0;
        p.data = int'(pixel_in);
        mpend.push_back(p);
      end
    end
    mfd = fd;
    ncyc++;
  endtask

  task automatic check_all();
    chk("mem_valid", int'(mem_valid), int'(mfifo.size() > 0));
    if (mfifo.size() > 0) begin
      chk("mem_addr", int'(mem_addr), mfifo[0].addr);
      chk("mem_data", int'(mem_data), mfifo[0].data);
    end
    chk("fifo_level", int'(fifo_level), mfifo.size());
    chk("frame_done", int'(frame_done), int'(mfd));
    chk("frame_count", int'(frame_count), mframes);
    chk("drop_count", int'(drop_count), mdrop);
    chk("oob_count", int'(oob_count), moob);
  endtask

  task automatic tick();
    if (rst_n && mem_valid && mem_ready && !frame_clear)
      wlog.push_back('{int'(mem_addr), int'(mem_data)});
    model_edge();
    @(posedge clk);
    #1;
    if (rst_n) check_all();
  endtask

  task automatic drive_px(input int h, input int v, input int d);
    pixel_valid = 1'b1; pixel_h = 11'(h); pixel_v = 10'(v); pixel_in = 16'(d);
  endtask

  task automatic drain(input string nm);
    int n;
    pixel_valid = 1'b0; mem_ready = 1'b1; n = 0;
    while ((mfifo.size() > 0 || mpend.size() > 0 || mem_valid) && n < 100) begin
      tick(); n++;
    end
    tick();
    chk({nm, "_drain_timeout"}, int'(n < 100), 1);
  endtask

  // Sends one raster frame with random mem_ready, throttled so the FIFO cannot overflow.
  task automatic send_frame(input string nm, output int pulses, output int at);
    int sent, start, n, bad;
    sent = 0; pulses = 0; at = -1; start = wlog.size(); n = 0;
    while (sent < FRAME && n < 1000) begin
      if (mfifo.size() + mpend.size() < 12) begin
        drive_px(sent % W, sent / W, 16'h4000 + sent); sent++;
      end else pixel_valid = 1'b0;
      mem_ready = ($urandom_range(0, 3) != 0);
      tick(); n++;
      if (frame_done) begin pulses++; at = wlog.size() - start; end
    end
    chk({nm, "_send_timeout"}, int'(n < 1000), 1);
    pixel_valid = 1'b0; mem_ready = 1'b1; n = 0;
    while ((mfifo.size() > 0 || mpend.size() > 0 || mem_valid) && n < 100) begin
      tick(); n++;
      if (frame_done) begin pulses++; at = wlog.size() - start; end
    end
    tick();
    if (frame_done) begin pulses++; at = wlog.size() - start; end
    bad = 0;
    for (int i = 0; i < FRAME; i++)
      if (start + i >= wlog.size() || wlog[start + i].addr != i) bad++;
    chk({nm, "_addr_order_errors"}, bad, 0);
    chk({nm, "_write_count"}, wlog.size() - start, FRAME);
  endtask

  initial begin
    vec_t vecs[7];
    int   p, at, base, lsz, n;

    vecs[0] = '{3, 2, 16'hF800, 1'b1, 19};
    vecs[1] = '{8, 0, 16'h1234, 1'b0, 0};
    vecs[2] = '{0, 4, 16'h5678, 1'b0, 0};
    vecs[3] = '{0, 0, 16'h0001, 1'b1, 0};
    vecs[4] = '{7, 3, 16'hABCD, 1'b1, 31};
    vecs[5] = '{7, 0, 16'hFFFF, 1'b1, 7};
    vecs[6] = '{2047, 1023, 16'h0F0F, 1'b0, 0};

    #23;
    chk("rst_mem_valid", int'(mem_valid), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_counts", int'(frame_count) + int'(drop_count) + int'(oob_count) + int'(mem_addr), 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    mem_ready = 1'b1;
    tick();

    // Table: single pixels, in range and out of range.
    foreach (vecs[i]) begin
      lsz = wlog.size();
      drive_px(vecs[i].h, vecs[i].v, vecs[i].data);
      tick();
      pixel_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_early_valid", i), int'(mem_valid), 0);
      tick();
      chk($sformatf("vec%0d_valid", i), int'(mem_valid), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_addr", i), int'(mem_addr), vecs[i].exp_addr);
        chk($sformatf("vec%0d_data", i), int'(mem_data), vecs[i].data);
      end
      tick();
      chk($sformatf("vec%0d_level", i), int'(fifo_level), 0);
      chk($sformatf("vec%0d_writes", i), wlog.size() - lsz, int'(vecs[i].exp_valid));
    end
    chk("table_oob", int'(oob_count), 3);
    chk("table_drop", int'(drop_count), 0);

    // Stalled memory with 18 pixels: 16 kept, 2 dropped, written in order afterwards.
    mem_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin drive_px(i % W, (i / W) % H, 16'h2000 + i); tick(); end
    pixel_valid = 1'b0;
    tick(); tick(); tick();
    chk("stall_level", int'(fifo_level), 16);
    chk("stall_drop", int'(drop_count), 2);
    chk("stall_head_addr", int'(mem_addr), 0);
    chk("stall_head_data", int'(mem_data), 16'h2000);
    lsz = wlog.size();
    drain("stall");
    n = 0;
    for (int i = 0; i < 16; i++)
      if (lsz + i >= wlog.size() || wlog[lsz + i].data != 16'h2000 + i ||
          wlog[lsz + i].addr != (i % W) + ((i / W) % H) * W) n++;
    chk("stall_order_errors", n, 0);
    chk("stall_write_count", wlog.size() - lsz, 16);

    // Full frames from a cleared write counter.
    frame_clear = 1'b1; tick(); frame_clear = 1'b0;
    base = int'(frame_count);
    send_frame("frame1", p, at);
    chk("frame1_pulses", p, 1);
    chk("frame1_pulse_pos", at, FRAME);
    chk("frame1_count", int'(frame_count), base + 1);
    send_frame("frame2", p, at);
    chk("frame2_pulses", p, 1);
    chk("frame2_count", int'(frame_count), base + 2);

    // Clear with 5 queued and a live handshake in the clear cycle.
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin drive_px(i, 0, 16'h3000 + i); tick(); end
    pixel_valid = 1'b0;
    tick(); tick();
    mem_ready = 1'b1;
    tick(); tick(); tick();
    chk("clr_pre_level", int'(fifo_level), 5);
    frame_clear = 1'b1; mem_ready = 1'b1;
    drive_px(1, 1, 16'hDEAD);
    tick();
    frame_clear = 1'b0; pixel_valid = 1'b0;
    chk("clr_level", int'(fifo_level), 0);
    chk("clr_valid", int'(mem_valid), 0);
    tick(); tick(); tick();
    chk("clr_no_ghost", int'(mem_valid), 0);
    send_frame("clr_frame", p, at);
    chk("clr_pulses", p, 1);
    chk("clr_pulse_pos", at, FRAME);

    // Randomized traffic including out-of-range pixels and occasional clears.
    for (int i = 0; i < 800; i++) begin
      pixel_valid = ($urandom_range(0, 1) == 1);
      pixel_h = 11'($urandom_range(0, 9));
      pixel_v = 10'($urandom_range(0, 5));
      pixel_in = 16'($urandom);
      mem_ready = ($urandom_range(0, 2) != 0);
      frame_clear = ($urandom_range(0, 63) == 0);
      tick();
    end
    frame_clear = 1'b0;

    // Asynchronous reset in the middle of a stalled burst.
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin drive_px(i, 1, 16'h5000 + i); tick(); end
    pixel_valid = 1'b0;
    tick();
    chk("mid_pre_valid", int'(mem_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(mem_valid), 0);
    chk("mid_rst_level", int'(fifo_level), 0);
    chk("mid_rst_done", int'(frame_done), 0);
    model_reset();
    tick(); tick();
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_frames", int'(frame_count), 0);
    chk("post_rst_drop", int'(drop_count), 0);
    chk("post_rst_oob", int'(oob_count), 0);
    chk("post_rst_valid", int'(mem_valid), 0);
    mem_ready = 1'b1;
    lsz = wlog.size();
    drive_px(3, 2, 16'hF800);
    tick();
    pixel_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_px_valid", int'(mem_valid), 1);
    chk("post_rst_px_addr", int'(mem_addr), 19);
    chk("post_rst_px_data", int'(mem_data), 16'hF800);
    tick();
    chk("post_rst_px_level", int'(fifo_level), 0);
    chk("post_rst_px_writes", wlog.size() - lsz, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
